// File: rtl/cpu_pkg.sv
// Shared control-unit / execute-stage definitions.
// Contents: datapath width, cuOPType operation encoding, shifter mode select.
package cpu_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned OP_W    = 6;

  // Operation codes produced by the control unit (values fixed by the ISA decode table).
  typedef enum logic [OP_W-1:0] {
    LUI   = 6'd0,  AUIPC = 6'd1,  JAL   = 6'd2,  JALR  = 6'd3,
    BEQ   = 6'd4,  BNE   = 6'd5,  BLT   = 6'd6,  BGE   = 6'd7,
    BLTU  = 6'd8,  BGEU  = 6'd9,  LB    = 6'd10, LH    = 6'd11,
    LW    = 6'd12, LBU   = 6'd13, LHU   = 6'd14, SB    = 6'd15,
    SH    = 6'd16, SW    = 6'd17, ADDI  = 6'd18, SLTI  = 6'd19,
    SLTIU = 6'd20, SLIU  = 6'd21, XORI  = 6'd22, ORI   = 6'd23,
    ANDI  = 6'd24, SLLI  = 6'd25, SRLI  = 6'd26, SRAI  = 6'd27,
    ADD   = 6'd28, SUB   = 6'd29, SLL   = 6'd30, SLT   = 6'd31,
    SLTU  = 6'd32, XOR   = 6'd33, SRL   = 6'd34, SRA   = 6'd35,
    OR    = 6'd36, AND   = 6'd37, ERROR = 6'd38
  } cu_op_t;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'd0,
    SHIFT_SRL = 2'd1,
    SHIFT_SRA = 2'd2
  } shift_mode_t;

endpackage

// File: rtl/rv32_shifter.sv
// Logarithmic barrel shifter for the execute-stage ALU.
// Ports: a (operand), shamt (shift amount 0..31), mode (SLL/SRL/SRA),
//        result_c (combinational shifted value).
module rv32_shifter
  import cpu_pkg::*;
(
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_mode_t        mode,
  output logic [WIDTH-1:0]   result_c
);

  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      r[i] = x[int'(WIDTH) - 1 - i];
    end
    return r;
  endfunction

  logic             fill;
  logic [WIDTH-1:0] stage;

  // Left shifts reuse the right-shift stages on a bit-reversed operand.
  always_comb begin
    fill     = 1'b0;
    stage    = '0;
    result_c = '0;
    fill     = (mode == SHIFT_SRA) && a[WIDTH-1];
    stage    = (mode == SHIFT_SLL) ? bit_reverse(a) : a;
    for (int i = 0; i < int'(SHAMT_W); i++) begin
      if (shamt[i]) begin
        stage = (stage >> (2 ** i)) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> (2 ** i)));
      end
    end
    result_c = (mode == SHIFT_SLL) ? bit_reverse(stage) : stage;
  end

endmodule

// File: rtl/rv32_alu.sv
// RV32I execute-stage integer ALU with a registered result.
// Ports: clk, nRst (async active-low), inputA/inputB (operands),
//        aluOP (cuOPType), ALUResult (registered), negative/zero (decoded from ALUResult).
module rv32_alu
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              nRst,
  input  logic [WIDTH-1:0]  inputA,
  input  logic [WIDTH-1:0]  inputB,
  input  logic [OP_W-1:0]   aluOP,
  output logic [WIDTH-1:0]  ALUResult,
  output logic              negative,
  output logic              zero
);

  shift_mode_t      shift_mode_c;
  logic [WIDTH-1:0] shift_result_c;
  logic [WIDTH-1:0] next_result_c;

  // Shift direction/kind from the opcode; only the low five bits of B are the amount.
  always_comb begin
    shift_mode_c = SHIFT_SLL;
    case (aluOP)
      SRL, SRLI: shift_mode_c = SHIFT_SRL;
      SRA, SRAI: shift_mode_c = SHIFT_SRA;
      default:   shift_mode_c = SHIFT_SLL;
    endcase
  end

  rv32_shifter u_shifter (
    .a        (inputA),
    .shamt    (inputB[SHAMT_W-1:0]),
    .mode     (shift_mode_c),
    .result_c (shift_result_c)
  );

  // Result select; branches use the difference so the control unit can read the flags.
  always_comb begin
    next_result_c = '0;
    case (aluOP)
      ADD, ADDI, AUIPC, JAL, JALR,
      LB, LH, LW, LBU, LHU, SB, SH, SW:       next_result_c = inputA + inputB;
      SUB, BEQ, BNE, BLT, BGE, BLTU, BGEU:    next_result_c = inputA - inputB;
      LUI:                                    next_result_c = inputB;
      SLT, SLTI:                              next_result_c = WIDTH'($signed(inputA) < $signed(inputB));
      SLTU, SLTIU, SLIU:                      next_result_c = WIDTH'(inputA < inputB);
      AND, ANDI:                              next_result_c = inputA & inputB;
      OR, ORI:                                next_result_c = inputA | inputB;
      XOR, XORI:                              next_result_c = inputA ^ inputB;
      SLL, SLLI, SRL, SRLI, SRA, SRAI:        next_result_c = shift_result_c;
      default:                                next_result_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      ALUResult <= '0;
    end else begin
      ALUResult <= next_result_c;
    end
  end

  // Flags follow the registered result directly.
  assign negative = ALUResult[WIDTH-1];
  assign zero     = (ALUResult == '0);

endmodule

// File: tb/tb_rv32_alu.sv
// Scoreboard testbench for rv32_alu: directed vectors plus random opcodes/operands
// checked against a behavioural model one rising edge after each input is applied.
module tb_rv32_alu;

  logic        clk;
  logic        nRst;
  logic [31:0] inputA;
  logic [31:0] inputB;
  logic [5:0]  aluOP;
  logic [31:0] ALUResult;
  logic        negative;
  logic        zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    int          op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];

  rv32_alu dut (
    .clk       (clk),
    .nRst      (nRst),
    .inputA    (inputA),
    .inputB    (inputB),
    .aluOP     (aluOP),
    .ALUResult (ALUResult),
    .negative  (negative),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic per operation class, keyed on the decimal encoding.
  function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    if (op == 0)                                   return b;
    if ((op >= 1 && op <= 3) || (op >= 10 && op <= 18) || op == 28) return a + b;
    if ((op >= 4 && op <= 9) || op == 29)          return a - b;
    if (op == 19 || op == 31)                      return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    if (op == 20 || op == 21 || op == 32)          return (a < b) ? 32'd1 : 32'd0;
    if (op == 22 || op == 33)                      return a ^ b;
    if (op == 23 || op == 36)                      return a | b;
    if (op == 24 || op == 37)                      return a & b;
    if (op == 25 || op == 30)                      return a << sh;
    if (op == 26 || op == 34)                      return a >> sh;
    if (op == 27 || op == 35)                      return 32'($signed(a) >>> sh);
    return 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive at the falling edge and record what the next rising edge must produce.
  task automatic apply(input int op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    aluOP  = 6'(op);
    inputA = a;
    inputB = b;
    e.res  = model(op, a, b);
    e.op   = op;
    e.a    = a;
    e.b    = b;
    sb.push_back(e);
  endtask

  // Monitor: the result is presented every cycle; compare one step after each rising edge.
  initial begin
    exp_t e;
    string tag;
    forever begin
      @(posedge clk);
      #1;
      if (nRst && sb.size() > 0) begin
        e   = sb.pop_front();
        tag = $sformatf("op%0d a=%08h b=%08h", e.op, e.a, e.b);
        check({tag, " result"}, ALUResult, e.res);
        check({tag, " negative"}, 32'(negative), 32'(e.res[31]));
        check({tag, " zero"}, 32'(zero), 32'(e.res == 32'd0));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sb.size());
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [5];
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h0000_0001;
    specials[2] = 32'h8000_0000;
    specials[3] = 32'h7FFF_FFFF;
    specials[4] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  initial begin
    int waited;
    nRst   = 1'b0;
    inputA = '0;
    inputB = '0;
    aluOP  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset result", ALUResult, 32'd0);
    check("reset zero", 32'(zero), 32'd1);
    check("reset negative", 32'(negative), 32'd0);
    @(negedge clk);
    nRst = 1'b1;

    // Shifts
    apply(30, 32'd256, 32'd3);
    apply(30, 32'hFFFF_FF00, 32'd3);
    apply(35, 32'hFFFF_FE70, 32'd3);
    apply(35, 32'd1000, 32'd3);
    apply(34, 32'd1000, 32'd2);
    apply(34, 32'h8000_0000, 32'd33);
    apply(30, 32'hDEAD_BEEF, 32'd0);
    apply(35, 32'h8000_0000, 32'd31);
    // Add/sub
    apply(28, 32'd40, 32'd90);
    apply(28, -32'sd8, -32'sd10);
    apply(28, 32'd10, -32'sd8);
    apply(28, -32'sd20, 32'd4);
    apply(29, -32'sd10, -32'sd5);
    apply(29, 32'd15, 32'd5);
    apply(29, 32'd20, -32'sd5);
    apply(29, -32'sd20, 32'd10);
    apply(29, 32'd10, 32'd10);
    apply(28, 32'h8000_0000, 32'hFFFF_FFFF);
    // Logic
    apply(36, 32'b0010, 32'b1101);
    apply(33, 32'b100011, 32'b101010);
    apply(37, 32'b100110, 32'b111100);
    // Compares
    apply(31, -32'sd15, 32'd10);
    apply(32, 32'd8, 32'd10);
    apply(32, 32'hFFFF_FFF1, 32'd10);
    apply(31, 32'h7FFF_FFFF, 32'h8000_0000);
    // Misc
    apply(0, 32'hABCD_0000, 32'h1234_5000);
    apply(38, 32'd5, 32'd7);
    apply(50, 32'd5, 32'd7);

    // Asynchronous reset in the middle of activity, between clock edges.
    apply(28, 32'd1, 32'd2);
    @(posedge clk);
    #3;
    nRst = 1'b0;
    #1;
    check("async reset result", ALUResult, 32'd0);
    check("async reset zero", 32'(zero), 32'd1);
    check("async reset negative", 32'(negative), 32'd0);
    @(posedge clk);
    #1;
    check("held reset result", ALUResult, 32'd0);
    apply(29, 32'd3, 32'd9);
    nRst = 1'b1;

    for (int n = 0; n < 400; n++) begin
      int op;
      op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(38, 63)) : int'($urandom_range(0, 37));
      apply(op, pick_operand(), pick_operand());
    end

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never observed, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
